// File: rtl/counter_pkg.sv
// counter_pkg: boundary-mode constants shared by the counter family
package counter_pkg;
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;
endpackage

// File: rtl/counter_step_alu.sv
// counter_step_alu: one modulo step of count by step_i within [0, max_val_i]; next_o = new value, cross_o = boundary crossed (assumes step_i <= max_val_i, count_i <= max_val_i)
module counter_step_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] max_val_i,
  input  logic             up_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] next_o,
  output logic             cross_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;
  always_comb begin
    sum     = {1'b0, count_i} + {1'b0, step_i};
    wrap_up = count_i + step_i - max_val_i - WIDTH'(1);
    wrap_dn = count_i - step_i + max_val_i + WIDTH'(1);
    cross_o = up_i ? (sum > {1'b0, max_val_i}) : (step_i > count_i);
    next_o  = up_i ? (cross_o ? (sat_i ? max_val_i : wrap_up) : sum[WIDTH-1:0])
                   : (cross_o ? (sat_i ? '0 : wrap_dn) : count_i - step_i);
  end
endmodule

// File: rtl/counter_up_down_mod.sv
// counter_up_down_mod: modulo up/down counter with run-time max_val, variable step, load, wrap/saturate, registered ovf/udf pulses and at_max/at_zero flags
module counter_up_down_mod
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4,
  parameter int SATURATE   = CNT_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  output logic [WIDTH-1:0]      count,
  output logic                  ovf,
  output logic                  udf,
  output logic                  at_max,
  output logic                  at_zero
);
  localparam logic SAT = (SATURATE == CNT_SAT);
  logic [WIDTH-1:0] count_q, count_d, step_ext, step_eff, alu_next;
  logic             ovf_q, ovf_d, udf_q, udf_d, alu_cross, oor, advance;
  always_comb begin
    step_ext = WIDTH'(step);
    step_eff = (step_ext > max_val) ? max_val : step_ext;
    oor      = count_q > max_val;
    advance  = !load && !oor && en;
    count_d  = load ? ((load_val > max_val) ? max_val : load_val)
             : oor ? max_val
             : en ? alu_next : count_q;
    ovf_d    = advance && up && alu_cross;
    udf_d    = advance && !up && alu_cross;
  end
  counter_step_alu #(.WIDTH(WIDTH)) u_alu (
    .count_i  (count_q),
    .step_i   (step_eff),
    .max_val_i(max_val),
    .up_i     (up),
    .sat_i    (SAT),
    .next_o   (alu_next),
    .cross_o  (alu_cross)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign at_max  = count_q == max_val;
  assign at_zero = count_q == '0;
endmodule

// File: tb/tb_counter_up_down_mod.sv
// tb_counter_up_down_mod: wrap and saturate counters driven in parallel, checked against an arithmetic reference model
module tb_counter_up_down_mod;
  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] step;
  logic [7:0] load_val, max_val;
  logic [7:0] count_w, count_s;
  logic       ovf_w, udf_w, at_max_w, at_zero_w;
  logic       ovf_s, udf_s, at_max_s, at_zero_s;
  int checks = 0;
  int errors = 0;
  int mw, ms;
  bit mow, muw, mos, mus;
  always #5 clk = ~clk;
  counter_up_down_mod #(.WIDTH(8), .STEP_WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .max_val(max_val), .count(count_w), .ovf(ovf_w),
    .udf(udf_w), .at_max(at_max_w), .at_zero(at_zero_w)
  );
  counter_up_down_mod #(.WIDTH(8), .STEP_WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .max_val(max_val), .count(count_s), .ovf(ovf_s),
    .udf(udf_s), .at_max(at_max_s), .at_zero(at_zero_s)
  );
  function automatic int model(input int c, input bit sat, output bit o, output bit u);
    int m = int'(max_val);
    int s = (int'(step) > m) ? m : int'(step);
    o = 1'b0;
    u = 1'b0;
    if (load) return (int'(load_val) > m) ? m : int'(load_val);
    if (c > m) return m;
    if (!en) return c;
    if (up) begin
      if (c + s > m) begin
        o = 1'b1;
        return sat ? m : (c + s) % (m + 1);
      end
      return c + s;
    end
    if (s > c) begin
      u = 1'b1;
      return sat ? 0 : (c - s + m + 1) % (m + 1);
    end
    return c - s;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("w_count", 32'(count_w), 32'(mw));
    chk("w_ovf", 32'(ovf_w), 32'(mow));
    chk("w_udf", 32'(udf_w), 32'(muw));
    chk("w_at_max", 32'(at_max_w), 32'(mw == int'(max_val)));
    chk("w_at_zero", 32'(at_zero_w), 32'(mw == 0));
    chk("s_count", 32'(count_s), 32'(ms));
    chk("s_ovf", 32'(ovf_s), 32'(mos));
    chk("s_udf", 32'(udf_s), 32'(mus));
    chk("s_at_max", 32'(at_max_s), 32'(ms == int'(max_val)));
    chk("s_at_zero", 32'(at_zero_s), 32'(ms == 0));
  endtask
  task automatic cyc();
    int nw, ns;
    nw = model(mw, 1'b0, mow, muw);
    ns = model(ms, 1'b1, mos, mus);
    @(posedge clk);
    #1;
    mw = nw;
    ms = ns;
    chk_all();
  endtask
  task automatic drive(input bit l, input int lv, input bit e, input bit u, input int st, input int m);
    load = l;
    load_val = 8'(lv);
    en = e;
    up = u;
    step = 4'(st);
    max_val = 8'(m);
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 9);
    mw = 0; ms = 0; mow = 0; muw = 0; mos = 0; mus = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;
    drive(1, 8, 0, 1, 3, 9); cyc();
    drive(0, 0, 1, 1, 3, 9); cyc();
    chk("wrap_up_count", 32'(count_w), 32'd1);
    chk("wrap_up_ovf", 32'(ovf_w), 32'd1);
    drive(0, 0, 0, 1, 3, 9); cyc();
    chk("wrap_up_ovf_clear", 32'(ovf_w), 32'd0);
    drive(1, 1, 0, 0, 3, 9); cyc();
    drive(0, 0, 1, 0, 3, 9); cyc();
    chk("wrap_dn_count", 32'(count_w), 32'd8);
    chk("sat_dn_count", 32'(count_s), 32'd0);
    drive(0, 0, 1, 0, 3, 9); cyc();
    chk("sat_dn_again_udf", 32'(udf_s), 32'd1);
    drive(1, 200, 1, 1, 3, 99); cyc();
    chk("load_clamp", 32'(count_w), 32'd99);
    chk("load_at_max", 32'(at_max_w), 32'd1);
    drive(1, 50, 0, 1, 1, 99); cyc();
    drive(0, 0, 1, 1, 1, 20); cyc();
    chk("shrink_clamp", 32'(count_w), 32'd20);
    drive(0, 0, 1, 1, 1, 20); cyc();
    chk("shrink_wrap_ovf", 32'(ovf_w), 32'd1);
    drive(1, 2, 0, 1, 15, 5); cyc();
    drive(0, 0, 1, 1, 15, 5); cyc();
    chk("step_clamp", 32'(count_w), 32'd1);
    drive(0, 0, 1, 1, 15, 0); cyc();
    drive(0, 0, 1, 0, 15, 0); cyc();
    chk("deg_at_max", 32'(at_max_w), 32'd1);
    drive(0, 0, 1, 1, 0, 9); cyc();
    drive(1, 7, 0, 1, 1, 9); cyc();
    #2;
    rst = 1'b1;
    #1;
    mw = 0; ms = 0; mow = 0; muw = 0; mos = 0; mus = 0;
    chk_all();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1, 1, 1, 9); cyc();
    chk("post_reset_count", 32'(count_w), 32'd1);
    for (int i = 0; i < 400; i++) begin
      int m;
      m = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
        : ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'(max_val);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 255), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15), m);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_up_down_mod.md
# counter_up_down_mod

Parametrised modulo up/down counter. Successor to the team's fixed-width binary up/down counter. Adds:
- a run-time modulus (`max_val`)
- a variable step size
- a synchronous parallel load
- compile-time wrap or saturate behaviour
- registered overflow/underflow pulses

It is the general-purpose counting primitive for timers, credit counters and address sequencers elsewhere in the design.

## Interface
- `WIDTH`, 8: width of `count`, `load_val`, `max_val`.
- `STEP_WIDTH`, 4: width of `step`. Must satisfy `STEP_WIDTH` ≤ `WIDTH`.
- `SATURATE`, 0: boundary behaviour. 0 = wrap modulo (`max_val`+1); 1 = clip at 0 / `max_val`.

Ports. The block uses one clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: count enable.
- `up` in 1: direction. 1 = increment, 0 = decrement.
- `step` in `STEP_WIDTH`: amount added or subtracted per enabled cycle.
- `load` in 1: synchronous load strobe.
- `load_val` in `WIDTH`: value to load.
- `max_val` in `WIDTH`: inclusive upper bound. Modulus is `max_val`+1.
- `count` out `WIDTH`: current value, registered.
- `ovf` out 1: one-cycle pulse. The previous enabled increment crossed `max_val`.
- `udf` out 1: one-cycle pulse. The previous enabled decrement crossed 0.
- `at_max` out 1: `count` == `max_val`. Combinational from `count`.
- `at_zero` out 1: `count` == 0. Combinational from `count`.

## Operation
- **Effective step.** `s` = min(`step`, `max_val`). This guarantees one conditional add/subtract of the modulus suffices. If `max_val` = 0, then `s` = 0 and `count` stays 0.
- **Priority per cycle, highest first:**
  1. `load`: `count` ← min(`load_val`, `max_val`). `ovf` and `udf` = 0.
  2. Out-of-range: `count` > `max_val` (after a run-time shrink of `max_val`). `count` ← `max_val`, no pulse, `en` ignored.
  3. `en` & `up`, computed at `WIDTH`+1 bits: sum = `count` + `s`.
     - If sum ≤ `max_val`: `count` ← sum.
     - Else, wrap mode: `count` ← sum − `max_val` − 1. Saturate mode: `count` ← `max_val`.
     - Either way, `ovf` = 1.
  4. `en` & !`up`:
     - If `s` ≤ `count`: `count` ← `count` − `s`.
     - Else, wrap mode: `count` ← `count` + `max_val` + 1 − `s`. Saturate mode: `count` ← 0.
     - Either way, `udf` = 1.
  5. Otherwise `count` holds and `ovf` = `udf` = 0.
- **Saturate mode, already at a boundary.** A further step past the boundary still pulses `ovf`/`udf` every enabled cycle; `count` is unchanged.
- **Step 0 with `en`.** `count` holds; no pulses.
- **Mutual exclusion.** `ovf` and `udf` are never both 1.

## Timing
- `count`, `ovf` and `udf` update on the rising `clk` edge. One-cycle latency from inputs sampled at edge N to outputs valid after edge N.
- `at_max` and `at_zero` follow `count` and `max_val` combinationally, with no extra latency.
- **Reset** (`rst` = 1, asynchronous assert, synchronous-safe deassert): `count` = 0, `ovf` = 0, `udf` = 0. Hence `at_zero` = 1, and `at_max` = 1 only if `max_val` = 0.
- **Reset mid-count.** Reset immediately clears the state. The first enabled edge after deassert counts from 0.
- `load` and `en` in the same cycle: load wins and the step is discarded.
- Inputs are sampled only at the rising edge. No handshake; `en` may be held high continuously.

## Structure
- **Shared package `counter_pkg`:** mode constants `CNT_WRAP` = 0 and `CNT_SAT` = 1, used for `SATURATE`.
- **Sub-module `counter_step_alu`:** combinational. Inputs: `count`, `s`, `max_val`, `up`, mode. Outputs: next count, crossing flag. It contains all `WIDTH`+1 arithmetic and the modulus correction, and is reused by the planned multi-channel timer.
- **Top level:** step clamp, priority mux, and the `count`/`ovf`/`udf` registers.

## Test plan
- **Wrap up.** `WIDTH`=8, `SATURATE`=0, `max_val`=9, `count`=8, `step`=3, `en`=`up`=1, one edge → `count`=1, `ovf`=1 for one cycle, then 0 while `en`=0.
- **Wrap down.** `max_val`=9, `count`=1, `step`=3, `up`=0 → `count`=8, `udf`=1. Repeat with `SATURATE`=1 → `count`=0, `udf`=1; next enabled edge → `count`=0, `udf`=1 again.
- **Load priority and clamp.** `load`=1, `load_val`=200, `max_val`=99, `en`=1 → `count`=99, `ovf`=`udf`=0, `at_max`=1.
- **Run-time shrink.** `count`=50, `max_val` changed to 20, `en`=1, `up`=1, `step`=1 → after one edge `count`=20 with no pulse; after the next, `count`=0 and `ovf`=1.
- **Step clamp and degenerate modulus.** `max_val`=5, `step`=15, `count`=2, up → `count`=1, `ovf`=1 (effective step 5). `max_val`=0, `en`=1 → `count` stays 0, no pulses, `at_max`=`at_zero`=1.
- **Async reset.** Assert `rst` mid-cycle while `count`=7 → `count`=0, `ovf`=`udf`=0 before the next clock edge. After deassert, `up`, `step`=1 → `count`=1.
